prbs_checker: RTL and testbench

Serial PRBS checker: the receive-side counterpart of the team's Fibonacci LFSR generator. It takes the generator's stream, one bit per `bit_valid` cycle, where each bit is generator `output_value[1]` taken before each shift. It self-synchronises to that stream, declares lock, then flags and counts bit errors. It sits at the far end of a link or loopback under test and feeds status registers and debug LEDs.

---
 rtl/prbs_checker.sv | 227 ++++++++++++++++++++++
 tb/tb_prbs_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS checker, receive-side partner of the Fibonacci LFSR
// generator. It self-synchronises to the stream, declares lock, then flags and
// counts bit errors.
//
// Optional feature: define PRBS_CHECKER_BITCOUNT_EN to add the bit_count port.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   bit_valid    bit_in is sampled this cycle
//   bit_in       received PRBS bit
//   clear_count  synchronous clear of error_count (and bit_count)
//   locked       registered, high while locked
//   error_pulse  registered, one-cycle strobe per detected error
//   error_count  saturating error count, ERR_W bits
//   bit_count    (PRBS_CHECKER_BITCOUNT_EN only) valid bits checked while locked
module prbs_checker #(
    parameter int unsigned N           = 4,
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned LOSS_WIN    = 32,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_count,
    output logic             locked,
    output logic             error_pulse,
    output logic [ERR_W-1:0] error_count
`ifdef PRBS_CHECKER_BITCOUNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int unsigned SW = $clog2(N + 1);
    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BW = $clog2(LOSS_WIN + 1);
    localparam int unsigned EW = $clog2(LOSS_THRESH + 1);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    generate
        if (N < 2 || N > 24) begin : g_bad_n
            $error("prbs_checker: N must be in 2..24");
        end
    endgenerate

    // Tap mask: bit k-1 set for tap position k, identical to the generator.
    function automatic logic [23:0] tap_mask_f(input int unsigned n);
        logic [23:0] m;
        m = '0;
        case (n)
            2:  begin m[1]  = 1'b1; m[0]  = 1'b1; end
            3:  begin m[2]  = 1'b1; m[1]  = 1'b1; end
            4:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
            5:  begin m[4]  = 1'b1; m[2]  = 1'b1; end
            6:  begin m[5]  = 1'b1; m[4]  = 1'b1; end
            7:  begin m[6]  = 1'b1; m[5]  = 1'b1; end
            8:  begin m[7]  = 1'b1; m[5]  = 1'b1; m[4]  = 1'b1; m[0]  = 1'b1; end
            9:  begin m[8]  = 1'b1; m[4]  = 1'b1; end
            10: begin m[9]  = 1'b1; m[6]  = 1'b1; end
            11: begin m[10] = 1'b1; m[8]  = 1'b1; end
            12: begin m[11] = 1'b1; m[10] = 1'b1; m[9]  = 1'b1; m[3]  = 1'b1; end
            13: begin m[12] = 1'b1; m[11] = 1'b1; m[10] = 1'b1; m[7]  = 1'b1; end
            14: begin m[13] = 1'b1; m[12] = 1'b1; m[11] = 1'b1; m[1]  = 1'b1; end
            15: begin m[14] = 1'b1; m[13] = 1'b1; end
            16: begin m[15] = 1'b1; m[14] = 1'b1; m[12] = 1'b1; m[3]  = 1'b1; end
            17: begin m[16] = 1'b1; m[2]  = 1'b1; end
            18: begin m[17] = 1'b1; m[10] = 1'b1; end
            19: begin m[18] = 1'b1; m[17] = 1'b1; m[16] = 1'b1; m[13] = 1'b1; end
            20: begin m[19] = 1'b1; m[16] = 1'b1; end
            21: begin m[20] = 1'b1; m[18] = 1'b1; end
            22: begin m[21] = 1'b1; m[20] = 1'b1; end
            23: begin m[22] = 1'b1; m[17] = 1'b1; end
            24: begin m[23] = 1'b1; m[22] = 1'b1; m[21] = 1'b1; m[16] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [23:0]  TAP_ALL = tap_mask_f(N);
    localparam logic [N-1:0] TAPS    = TAP_ALL[N-1:0];

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     r_q, r_d;          // r[k] of the description lives at bit k-1
    logic [SW-1:0]    srch_q, srch_d;
    logic [MW-1:0]    match_q, match_d;
    logic [BW-1:0]    wbits_q, wbits_d;
    logic [EW-1:0]    werr_q, werr_d;
    logic [EW-1:0]    werr_inc;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             locked_q;
    logic             pred;
    logic             mism;
`ifdef PRBS_CHECKER_BITCOUNT_EN
    logic [31:0]      bcnt_q, bcnt_d;
`endif

    assign pred     = ^(r_q & TAPS);
    assign mism     = bit_in ^ pred;
    assign werr_inc = werr_q + EW'(1);

    // Next-state: search/verify/locked sequencing, window tracking, counters.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        srch_d  = srch_q;
        match_d = match_q;
        wbits_d = wbits_q;
        werr_d  = werr_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef PRBS_CHECKER_BITCOUNT_EN
        bcnt_d  = bcnt_q;
`endif
        if (bit_valid) begin
            case (state_q)
                S_SEARCH: begin
                    r_d = {bit_in, r_q[N-1:1]};
                    if (srch_q == SW'(N - 1)) begin
                        state_d = S_VERIFY;
                        srch_d  = '0;
                        match_d = '0;
                    end else begin
                        srch_d = srch_q + SW'(1);
                    end
                end
                S_VERIFY: begin
                    r_d = {bit_in, r_q[N-1:1]};
                    // A zero register predicting a zero bit is the lock-up state; never credit it.
                    if (!mism && !(r_q == '0 && !bit_in)) begin
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = S_LOCKED;
                            match_d = '0;
                            wbits_d = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                S_LOCKED: begin
                    // Flywheel on the prediction so a flipped line bit cannot corrupt r.
                    r_d = {pred, r_q[N-1:1]};
`ifdef PRBS_CHECKER_BITCOUNT_EN
                    bcnt_d = bcnt_q + 32'd1;
`endif
                    if (mism) begin
                        pulse_d = 1'b1;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + ERR_W'(1);
                        end
                    end
                    if (mism && werr_inc == EW'(LOSS_THRESH)) begin
                        state_d = S_SEARCH;
                        r_d     = '0;
                        srch_d  = '0;
                        wbits_d = '0;
                        werr_d  = '0;
                    end else if (wbits_q == BW'(LOSS_WIN - 1)) begin
                        wbits_d = '0;
                        werr_d  = '0;
                    end else begin
                        wbits_d = wbits_q + BW'(1);
                        if (mism) begin
                            werr_d = werr_inc;
                        end
                    end
                end
                default: state_d = S_SEARCH;
            endcase
        end
        if (clear_count) begin
            cnt_d = '0;
`ifdef PRBS_CHECKER_BITCOUNT_EN
            bcnt_d = '0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_SEARCH;
            r_q      <= '0;
            srch_q   <= '0;
            match_q  <= '0;
            wbits_q  <= '0;
            werr_q   <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
`ifdef PRBS_CHECKER_BITCOUNT_EN
            bcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            srch_q   <= srch_d;
            match_q  <= match_d;
            wbits_q  <= wbits_d;
            werr_q   <= werr_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            locked_q <= (state_d == S_LOCKED);
`ifdef PRBS_CHECKER_BITCOUNT_EN
            bcnt_q   <= bcnt_d;
`endif
        end
    end

    assign locked      = locked_q;
    assign error_pulse = pulse_q;
    assign error_count = cnt_q;
`ifdef PRBS_CHECKER_BITCOUNT_EN
    assign bit_count   = bcnt_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker (N=4, generator seed 4'b1000). A default-width
// instance and an ERR_W=4 instance share the same stimulus.
// Optional feature under test when defined: PRBS_CHECKER_BITCOUNT_EN.
module tb_prbs_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        clear_count = 1'b0;
    logic        locked, error_pulse;
    logic [15:0] error_count;
    logic        locked4, error_pulse4;
    logic [3:0]  error_count4;
`ifdef PRBS_CHECKER_BITCOUNT_EN
    logic [31:0] bit_count, bit_count4;
`endif

    prbs_checker dut (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .clear_count(clear_count), .locked(locked), .error_pulse(error_pulse),
        .error_count(error_count)
`ifdef PRBS_CHECKER_BITCOUNT_EN
        , .bit_count(bit_count)
`endif
    );

    prbs_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .clear_count(clear_count), .locked(locked4), .error_pulse(error_pulse4),
        .error_count(error_count4)
`ifdef PRBS_CHECKER_BITCOUNT_EN
        , .bit_count(bit_count4)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] gen_q = 4'b1000;

    typedef struct packed {
        logic        v;
        logic        b;
        logic        c;
        logic        lk;
        logic        pl;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv [29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        @(negedge clk);
        bit_valid   = v;
        bit_in      = b;
        clear_count = c;
        @(posedge clk);
        #1;
    endtask

    // Reference generator: emits state[1] then shifts feedback into the top.
    task automatic gen_bit(output logic b);
        b     = gen_q[0];
        gen_q = {gen_q[3] ^ gen_q[2], gen_q[3:1]};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        clear_count = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        gen_q = 4'b1000;
    endtask

    function automatic vec_t mk(input logic v, input logic b, input logic c,
                                input logic lk, input logic pl, input logic [15:0] cnt);
        vec_t t;
        t.v = v; t.b = b; t.c = c; t.lk = lk; t.pl = pl; t.cnt = cnt;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic b;
        logic h1, h2;
        int   first_lock, pulses, drops, seen, vcnt, bad;
        logic v;

        // Stream from seed 1000: 0,0,0 then repeating 1,1,0. Gaps carry junk bits.
        tv[0]  = mk(1, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 0, 0, 0, 0, 0);
        tv[2]  = mk(1, 0, 0, 0, 0, 0);
        tv[3]  = mk(0, 1, 0, 0, 0, 0);
        tv[4]  = mk(1, 1, 0, 0, 0, 0);
        tv[5]  = mk(1, 1, 0, 0, 0, 0);
        tv[6]  = mk(1, 0, 0, 0, 0, 0);
        tv[7]  = mk(1, 1, 0, 0, 0, 0);
        tv[8]  = mk(1, 1, 0, 0, 0, 0);
        tv[9]  = mk(1, 0, 0, 0, 0, 0);
        tv[10] = mk(1, 1, 0, 0, 0, 0);
        tv[11] = mk(0, 0, 0, 0, 0, 0);
        tv[12] = mk(1, 1, 0, 0, 0, 0);
        tv[13] = mk(1, 0, 0, 0, 0, 0);
        tv[14] = mk(1, 1, 0, 0, 0, 0);
        tv[15] = mk(1, 1, 0, 0, 0, 0);
        tv[16] = mk(1, 0, 0, 0, 0, 0);
        tv[17] = mk(1, 1, 0, 0, 0, 0);
        tv[18] = mk(1, 1, 0, 0, 0, 0);
        tv[19] = mk(1, 0, 0, 0, 0, 0);
        tv[20] = mk(1, 1, 0, 0, 0, 0);
        tv[21] = mk(1, 1, 0, 1, 0, 0);   // 20th valid bit: lock
        tv[22] = mk(1, 0, 0, 1, 0, 0);
        tv[23] = mk(1, 1, 0, 1, 0, 0);
        tv[24] = mk(1, 1, 0, 1, 0, 0);
        tv[25] = mk(1, 1, 0, 1, 1, 1);   // true bit 0, sent inverted
        tv[26] = mk(1, 1, 0, 1, 0, 1);
        tv[27] = mk(0, 0, 1, 1, 0, 0);   // clear during an idle cycle
        tv[28] = mk(1, 1, 0, 1, 0, 0);

        // Reset values
        do_reset();
        check("reset_locked", 32'(locked), 0);
        check("reset_pulse", 32'(error_pulse), 0);
        check("reset_count", 32'(error_count), 0);
`ifdef PRBS_CHECKER_BITCOUNT_EN
        check("reset_bit_count", bit_count, 0);
`endif

        // Table-driven first lock, single error and clear
        for (int i = 0; i < 29; i++) begin
            step(tv[i].v, tv[i].b, tv[i].c);
            check($sformatf("vec%0d_locked", i), 32'(locked), 32'(tv[i].lk));
            check($sformatf("vec%0d_pulse", i), 32'(error_pulse), 32'(tv[i].pl));
            check($sformatf("vec%0d_count", i), 32'(error_count), 32'(tv[i].cnt));
        end

        // Clean stream of 1000 bits
        do_reset();
        first_lock = 0; pulses = 0; drops = 0;
        for (int i = 1; i <= 1000; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            if (locked && first_lock == 0) first_lock = i;
            if (!locked && first_lock != 0) drops++;
            if (error_pulse) pulses++;
        end
        check("clean_lock_bit", 32'(first_lock), 20);
        check("clean_drops", 32'(drops), 0);
        check("clean_pulses", 32'(pulses), 0);
        check("clean_count", 32'(error_count), 0);
`ifdef PRBS_CHECKER_BITCOUNT_EN
        check("clean_bit_count", bit_count, 980);
        step(1'b0, 1'b0, 1'b1);
        check("clear_bit_count", bit_count, 0);
`endif

        // Four errors inside one window: loss of lock, then relock
        do_reset();
        for (int i = 0; i < 30; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
        end
        check("loss_pre_locked", 32'(locked), 1);
        for (int e = 1; e <= 4; e++) begin
            for (int i = 0; i < 4; i++) begin
                gen_bit(b);
                step(1'b1, b, 1'b0);
            end
            gen_bit(b);
            step(1'b1, ~b, 1'b0);
            check($sformatf("loss_err%0d_pulse", e), 32'(error_pulse), 1);
            check($sformatf("loss_err%0d_count", e), 32'(error_count), 32'(e));
            check($sformatf("loss_err%0d_locked", e), 32'(locked), (e < 4) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 20; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            if (i == 1) check("relock_pulse_cleared", 32'(error_pulse), 0);
            if (i == 19) check("relock_bit19", 32'(locked), 0);
            if (i == 20) check("relock_bit20", 32'(locked), 1);
        end
        check("relock_count_held", 32'(error_count), 4);

        // All-zero stream never locks
        do_reset();
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (locked) seen++;
        end
        check("zero_stream_lock", 32'(seen), 0);

        // Random non-PRBS stream, with a forced misprediction every 10th bit
        do_reset();
        seen = 0; h1 = 1'b0; h2 = 1'b0;
        for (int i = 1; i <= 500; i++) begin
            b = 1'($urandom % 2);
            if (i % 10 == 0) b = ~(h1 ^ h2);
            step(1'b1, b, 1'b0);
            h2 = h1; h1 = b;
            if (locked) seen++;
        end
        check("random_stream_lock", 32'(seen), 0);

        // Random bit_valid gaps
        do_reset();
        vcnt = 0; bad = 0;
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom % 2);
            if (v) gen_bit(b);
            else   b = 1'($urandom % 2);
            step(v, b, 1'b0);
            if (v) vcnt++;
            if (locked !== (vcnt >= 20)) bad++;
        end
        check("gap_lock_track", 32'(bad), 0);
        check("gap_count", 32'(error_count), 0);
        check("gap_locked", 32'(locked), 1);

        // Asynchronous reset mid-lock while an error pulse is high
        gen_bit(b);
        step(1'b1, ~b, 1'b0);
        check("prereset_pulse", 32'(error_pulse), 1);
        check("prereset_count", 32'(error_count), 1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_locked", 32'(locked), 0);
        check("async_reset_pulse", 32'(error_pulse), 0);
        check("async_reset_count", 32'(error_count), 0);
        @(negedge clk);
        reset = 1'b0;
        gen_q = 4'b1000;

        // Saturation at 15 for ERR_W=4, errors spaced 11 bits apart
        for (int i = 0; i < 20; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
        end
        check("sat_locked_start", 32'(locked4), 1);
        for (int e = 1; e <= 20; e++) begin
            for (int i = 0; i < 10; i++) begin
                gen_bit(b);
                step(1'b1, b, 1'b0);
            end
            gen_bit(b);
            step(1'b1, ~b, 1'b0);
            check($sformatf("sat_err%0d_count4", e), 32'(error_count4), (e < 15) ? 32'(e) : 32'd15);
        end
        check("sat_count16", 32'(error_count), 20);
        check("sat_locked_end", 32'(locked4), 1);

        // clear_count coinciding with an error
        for (int i = 0; i < 10; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
        end
        gen_bit(b);
        step(1'b1, ~b, 1'b1);
        check("clr_err_pulse4", 32'(error_pulse4), 1);
        check("clr_err_count4", 32'(error_count4), 0);
        check("clr_err_pulse", 32'(error_pulse), 1);
        check("clr_err_count", 32'(error_count), 0);
        check("clr_err_locked", 32'(locked), 1);
        step(1'b0, 1'b0, 1'b0);
        check("clr_pulse_one_cycle", 32'(error_pulse), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
